// File: rtl/leds7_uart_display.sv
// Seven-segment display controller fed by an AXI-Stream byte stream: hex characters
// fill a shadow buffer, control bytes commit, clear, edit or blink the displayed digits.
module leds7_uart_display #(
  parameter int unsigned CLK_FREQ = 50,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [7:0]        tdata,
  input  logic              tvalid,
  output logic              tready,
  output logic [6:0]        leds_data [DIGITS],
  output logic [DIGITS-1:0] led_data_valid,
  output logic [7:0]        err_cnt
);

  localparam int unsigned HP    = CLK_FREQ * 1_000_000 / (2 * BLINK_HZ);
  localparam int unsigned CNT_W = (HP > 1) ? $clog2(HP) : 1;
  localparam logic [4:0]  CODE_DASH  = 5'd16;
  localparam logic [4:0]  CODE_BLANK = 5'd17;

  logic             r_tready;
  logic             r_in_valid;
  logic [7:0]       r_in_data;
  logic [4:0]       r_shadow  [DIGITS];
  logic [4:0]       r_display [DIGITS];
  logic             r_blink_en;
  logic             r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_err;
  logic [6:0]       r_leds [DIGITS];
  logic [DIGITS-1:0] r_vld;

  logic       w_shift_up;
  logic       w_shift_dn;
  logic       w_commit;
  logic       w_clear;
  logic       w_bel;
  logic       w_err;
  logic [4:0] w_code;

  function automatic logic [6:0] seg_lut(input logic [4:0] code);
    case (code)
      5'd0:    seg_lut = 7'h40;
      5'd1:    seg_lut = 7'h79;
      5'd2:    seg_lut = 7'h24;
      5'd3:    seg_lut = 7'h30;
      5'd4:    seg_lut = 7'h19;
      5'd5:    seg_lut = 7'h12;
      5'd6:    seg_lut = 7'h02;
      5'd7:    seg_lut = 7'h78;
      5'd8:    seg_lut = 7'h00;
      5'd9:    seg_lut = 7'h10;
      5'd10:   seg_lut = 7'h08;
      5'd11:   seg_lut = 7'h03;
      5'd12:   seg_lut = 7'h46;
      5'd13:   seg_lut = 7'h21;
      5'd14:   seg_lut = 7'h06;
      5'd15:   seg_lut = 7'h0E;
      5'd16:   seg_lut = 7'h3F;
      default: seg_lut = 7'h7F;
    endcase
  endfunction

  // Input register: one byte per cycle, always ready once out of reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tready   <= 1'b0;
      r_in_valid <= 1'b0;
      r_in_data  <= 8'h00;
    end else begin
      r_tready   <= 1'b1;
      r_in_valid <= tvalid && r_tready;
      if (tvalid && r_tready) r_in_data <= tdata;
    end
  end

  // Byte decode of the captured character
  always_comb begin
    w_shift_up = 1'b0;
    w_shift_dn = 1'b0;
    w_commit   = 1'b0;
    w_clear    = 1'b0;
    w_bel      = 1'b0;
    w_err      = 1'b0;
    w_code     = CODE_BLANK;
    if (r_in_valid) begin
      if (r_in_data >= 8'h30 && r_in_data <= 8'h39) begin
        w_shift_up = 1'b1;
        w_code     = 5'(r_in_data - 8'h30);
      end else if (r_in_data >= 8'h41 && r_in_data <= 8'h46) begin
        w_shift_up = 1'b1;
        w_code     = 5'(r_in_data - 8'h37);
      end else if (r_in_data >= 8'h61 && r_in_data <= 8'h66) begin
        w_shift_up = 1'b1;
        w_code     = 5'(r_in_data - 8'h57);
      end else if (r_in_data == 8'h2D) begin
        w_shift_up = 1'b1;
        w_code     = CODE_DASH;
      end else if (r_in_data == 8'h20) begin
        w_shift_up = 1'b1;
      end else if (r_in_data == 8'h08) begin
        w_shift_dn = 1'b1;
      end else if (r_in_data == 8'h0D) begin
        w_commit = 1'b1;
      end else if (r_in_data == 8'h1B) begin
        w_clear = 1'b1;
      end else if (r_in_data == 8'h07) begin
        w_bel = 1'b1;
      end else begin
        w_err = 1'b1;
      end
    end
  end

  // Buffers, error counter and blink timing
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DIGITS; i++) begin
        r_shadow[i]  <= CODE_BLANK;
        r_display[i] <= CODE_BLANK;
      end
      r_blink_en <= 1'b0;
      r_phase    <= 1'b1;
      r_cnt      <= '0;
      r_err      <= 8'h00;
    end else begin
      if (w_shift_up) begin
        for (int i = DIGITS - 1; i > 0; i--) r_shadow[i] <= r_shadow[i-1];
        r_shadow[0] <= w_code;
      end
      if (w_shift_dn) begin
        for (int i = 0; i < DIGITS - 1; i++) r_shadow[i] <= r_shadow[i+1];
        r_shadow[DIGITS-1] <= CODE_BLANK;
      end
      if (w_commit) r_display <= r_shadow;
      if (w_clear) begin
        for (int i = 0; i < DIGITS; i++) begin
          r_shadow[i]  <= CODE_BLANK;
          r_display[i] <= CODE_BLANK;
        end
      end
      if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
      // BEL takes priority over a simultaneous counter wrap
      if (w_bel) begin
        r_blink_en <= ~r_blink_en;
        r_cnt      <= '0;
        r_phase    <= 1'b1;
      end else if (r_blink_en) begin
        if (r_cnt == CNT_W'(HP - 1)) begin
          r_cnt   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt   <= '0;
        r_phase <= 1'b1;
      end
    end
  end

  // Registered segment outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DIGITS; i++) r_leds[i] <= 7'h7F;
      r_vld <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (r_display[i] != CODE_BLANK && (r_phase || !r_blink_en)) begin
          r_leds[i] <= seg_lut(r_display[i]);
          r_vld[i]  <= 1'b1;
        end else begin
          r_leds[i] <= 7'h7F;
          r_vld[i]  <= 1'b0;
        end
      end
    end
  end

  assign tready         = r_tready;
  assign leds_data      = r_leds;
  assign led_data_valid = r_vld;
  assign err_cnt        = r_err;

endmodule

// File: tb/tb_leds7_uart_display.sv
// Bench for leds7_uart_display: a 4-digit and a 1-digit instance share one byte stream.
module tb_leds7_uart_display;

  localparam logic [27:0] BLANK4 = 28'hFFFFFFF;

  typedef struct packed {
    logic [27:0] leds;
    logic [3:0]  vld;
    logic [6:0]  leds1;
    logic        vld1;
  } exp_t;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       tvalid = 1'b0;

  logic       rdy4;
  logic [6:0] leds4 [4];
  logic [3:0] vld4;
  logic [7:0] err4;
  logic       rdy1;
  logic [6:0] leds1 [1];
  logic [0:0] vld1;
  logic [7:0] err1;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 aclk = ~aclk;

  leds7_uart_display #(.CLK_FREQ(1), .DIGITS(4), .BLINK_HZ(1000)) u_dut4 (
    .aclk(aclk), .aresetn(aresetn), .tdata(tdata), .tvalid(tvalid), .tready(rdy4),
    .leds_data(leds4), .led_data_valid(vld4), .err_cnt(err4)
  );

  leds7_uart_display #(.CLK_FREQ(1), .DIGITS(1), .BLINK_HZ(1000)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .tdata(tdata), .tvalid(tvalid), .tready(rdy1),
    .leds_data(leds1), .led_data_valid(vld1), .err_cnt(err1)
  );

  function automatic logic [27:0] obs_leds();
    return {leds4[3], leds4[2], leds4[1], leds4[0]};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    tdata  = b;
    tvalid = 1'b1;
    @(posedge aclk);
    #1;
    tvalid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      tdata  = s[i];
      tvalid = 1'b1;
      @(posedge aclk);
      #1;
    end
    tvalid = 1'b0;
  endtask

  task automatic test_reset();
    wait_cyc(2);
    checks++;
    if (obs_leds() !== BLANK4 || leds1[0] !== 7'h7F) begin
      errors++;
      $display("FAIL reset_leds got=%h/%h expected=%h/7f", obs_leds(), leds1[0], BLANK4);
    end
    checks++;
    if (vld4 !== 4'b0000 || vld1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b/%b expected=0000/0", vld4, vld1);
    end
    checks++;
    if (rdy4 !== 1'b0 || rdy1 !== 1'b0 || err4 !== 8'd0) begin
      errors++;
      $display("FAIL reset_ready_err got rdy=%b/%b err=%0d expected 0/0 err=0", rdy4, rdy1, err4);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    checks++;
    if (rdy4 !== 1'b1 || rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b/%b expected=1/1", rdy4, rdy1);
    end
  endtask

  task automatic test_basic_commit();
    exp_t e;
    send_str("12Ab");
    sb_q.push_back('{leds: BLANK4, vld: 4'b0000, leds1: 7'h7F, vld1: 1'b0});
    wait_cyc(2);
    e = sb_q.pop_front();
    checks++;
    if ({obs_leds(), vld4} !== {e.leds, e.vld}) begin
      errors++;
      $display("FAIL precommit_blank got=%h/%b expected=%h/%b", obs_leds(), vld4, e.leds, e.vld);
    end
    send_byte(8'h0D);
    sb_q.push_back('{leds: {7'h79, 7'h24, 7'h08, 7'h03}, vld: 4'b1111, leds1: 7'h03, vld1: 1'b1});
    wait_cyc(1);
    checks++;
    if (obs_leds() !== BLANK4) begin
      errors++;
      $display("FAIL commit_latency got=%h expected=%h one cycle after CR", obs_leds(), BLANK4);
    end
    wait_cyc(1);
    e = sb_q.pop_front();
    checks++;
    if ({obs_leds(), vld4} !== {e.leds, e.vld}) begin
      errors++;
      $display("FAIL basic_commit got=%h/%b expected=%h/%b", obs_leds(), vld4, e.leds, e.vld);
    end
    checks++;
    if ({leds1[0], vld1} !== {e.leds1, e.vld1}) begin
      errors++;
      $display("FAIL basic_commit_1dig got=%h/%b expected=%h/%b", leds1[0], vld1, e.leds1, e.vld1);
    end
  endtask

  task automatic test_overflow_bs();
    exp_t e;
    send_str("123456");
    send_byte(8'h08);
    send_byte(8'h0D);
    sb_q.push_back('{leds: {7'h7F, 7'h30, 7'h19, 7'h12}, vld: 4'b0111, leds1: 7'h7F, vld1: 1'b0});
    wait_cyc(2);
    e = sb_q.pop_front();
    checks++;
    if ({obs_leds(), vld4} !== {e.leds, e.vld}) begin
      errors++;
      $display("FAIL overflow_bs got=%h/%b expected=%h/%b", obs_leds(), vld4, e.leds, e.vld);
    end
    checks++;
    if ({leds1[0], vld1} !== {e.leds1, e.vld1}) begin
      errors++;
      $display("FAIL overflow_bs_1dig got=%h/%b expected=%h/%b", leds1[0], vld1, e.leds1, e.vld1);
    end
  endtask

  task automatic test_errors();
    exp_t e;
    send_byte(8'h47);
    send_byte(8'h00);
    send_byte(8'hFF);
    sb_q.push_back('{leds: {7'h7F, 7'h30, 7'h19, 7'h12}, vld: 4'b0111, leds1: 7'h7F, vld1: 1'b0});
    wait_cyc(1);
    checks++;
    if (err4 !== 8'd3 || err1 !== 8'd3) begin
      errors++;
      $display("FAIL err_cnt_three got=%0d/%0d expected=3", err4, err1);
    end
    wait_cyc(1);
    e = sb_q.pop_front();
    checks++;
    if ({obs_leds(), vld4} !== {e.leds, e.vld}) begin
      errors++;
      $display("FAIL err_display_kept got=%h/%b expected=%h/%b", obs_leds(), vld4, e.leds, e.vld);
    end
    for (int i = 0; i < 251; i++) begin
      tdata  = 8'(8'h80 + i % 64);
      tvalid = 1'b1;
      @(posedge aclk);
      #1;
    end
    tvalid = 1'b0;
    wait_cyc(1);
    checks++;
    if (err4 !== 8'd254) begin
      errors++;
      $display("FAIL err_cnt_254 got=%0d expected=254", err4);
    end
    for (int i = 0; i < 49; i++) begin
      tdata  = 8'hC3;
      tvalid = 1'b1;
      @(posedge aclk);
      #1;
    end
    tvalid = 1'b0;
    wait_cyc(1);
    checks++;
    if (err4 !== 8'd255 || err1 !== 8'd255) begin
      errors++;
      $display("FAIL err_cnt_saturate got=%0d/%0d expected=255", err4, err1);
    end
  endtask

  task automatic test_blink();
    exp_t e;
    int   mism;
    send_byte(8'h1B);
    send_str("8888");
    send_byte(8'h0D);
    sb_q.push_back('{leds: 28'h0, vld: 4'b1111, leds1: 7'h00, vld1: 1'b1});
    wait_cyc(2);
    e = sb_q.pop_front();
    checks++;
    if ({obs_leds(), vld4, leds1[0], vld1} !== {e.leds, e.vld, e.leds1, e.vld1}) begin
      errors++;
      $display("FAIL blink_commit got=%h/%b expected=%h/%b", obs_leds(), vld4, e.leds, e.vld);
    end
    // BEL captured here, decoded at the next edge E
    send_byte(8'h07);
    wait_cyc(1);
    mism = 0;
    for (int j = 1; j <= 1500; j++) begin
      logic        lit;
      logic [27:0] el;
      wait_cyc(1);
      lit = (((j - 1) / 500) % 2) == 0;
      el  = lit ? 28'h0 : BLANK4;
      if (vld4 !== {4{lit}} || obs_leds() !== el || vld1 !== lit) mism++;
      if (j == 500 || j == 501 || j == 1000 || j == 1001) begin
        checks++;
        if (vld4 !== {4{lit}}) begin
          errors++;
          $display("FAIL blink_edge j=%0d got=%b expected=%b", j, vld4, {4{lit}});
        end
      end
    end
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL blink_pattern bad_cycles got=%0d expected=0", mism);
    end
    send_byte(8'h07);
    wait_cyc(2);
    mism = 0;
    for (int j = 0; j < 1100; j++) begin
      if (vld4 !== 4'b1111 || obs_leds() !== 28'h0 || vld1 !== 1'b1) mism++;
      wait_cyc(1);
    end
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL blink_off_steady bad_cycles got=%0d expected=0", mism);
    end
  endtask

  task automatic test_esc_midreset();
    exp_t e;
    send_byte(8'h1B);
    sb_q.push_back('{leds: BLANK4, vld: 4'b0000, leds1: 7'h7F, vld1: 1'b0});
    wait_cyc(2);
    e = sb_q.pop_front();
    checks++;
    if ({obs_leds(), vld4, vld1} !== {e.leds, e.vld, e.vld1}) begin
      errors++;
      $display("FAIL esc_blank got=%h/%b expected=%h/%b", obs_leds(), vld4, e.leds, e.vld);
    end
    send_str("12");
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (rdy4 !== 1'b0 || err4 !== 8'd0 || err1 !== 8'd0 || vld4 !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got rdy=%b err=%0d/%0d vld=%b expected rdy=0 err=0 vld=0000",
               rdy4, err4, err1, vld4);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send_byte(8'h0D);
    sb_q.push_back('{leds: BLANK4, vld: 4'b0000, leds1: 7'h7F, vld1: 1'b0});
    wait_cyc(2);
    e = sb_q.pop_front();
    checks++;
    if ({obs_leds(), vld4, leds1[0], vld1} !== {e.leds, e.vld, e.leds1, e.vld1}) begin
      errors++;
      $display("FAIL midreset_commit got=%h/%b expected=%h/%b", obs_leds(), vld4, e.leds, e.vld);
    end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_overflow_bs();
    test_errors();
    test_blink();
    test_esc_midreset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
